// File: rtl/busarb_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
// No logic of its own; imported by busarb and busarb_rr.
package busarb_pkg;

  localparam int BUSARB_ADDR_W   = 17;
  localparam int BUSARB_DATA_W   = 8;
  localparam int BUSARB_READ_LAT = 1;
  localparam int BUSARB_CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } busarb_state_t;

  typedef logic mid_t;

endpackage

// File: rtl/busarb_rr.sv
// Two-input round-robin picker; a tie goes to the master not granted last.
// Combinational, zero latency; a zero lock-mask bit hides that master's request.
module busarb_rr
  import busarb_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last_gnt,
  input  logic [1:0] mask,
  output logic       gnt_valid,
  output mid_t       gnt_id
);

  logic [1:0] eff_req;

  assign eff_req = req & mask;

  always_comb begin
    gnt_valid = |eff_req;
    gnt_id    = 1'b0;
    if (eff_req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else if (eff_req[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/busarb.sv
// Serialises single-byte m0/m1 transactions onto busctl; BUSARB_LOCK_EN adds grant locking.
// Ack arrives 2 + READ_LAT cycles after the request is sampled; one transfer per 3 + READ_LAT cycles.
// Masters hold req until ack; requests are only sampled in IDLE.
module busarb
  import busarb_pkg::*;
#(
  parameter int ADDR_W   = BUSARB_ADDR_W,
  parameter int DATA_W   = BUSARB_DATA_W,
  parameter int READ_LAT = BUSARB_READ_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
`ifdef BUSARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  busarb_state_t           state;
  mid_t                    last_gnt;
  mid_t                    gnt_id;
  logic [BUSARB_CNT_W-1:0] cnt;
  logic [1:0]              lock_mask;
  logic                    rr_vld;
  mid_t                    rr_id;

`ifdef BUSARB_LOCK_EN
  logic lock_act;
  mid_t lock_id;

  assign lock_mask = lock_act ? (lock_id ? 2'b10 : 2'b01) : 2'b11;

  // Any IDLE cycle consumes the lock: either the holder is granted (and DONE
  // re-arms it) or the holder has gone quiet and arbitration reopens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_act <= 1'b0;
      lock_id  <= 1'b0;
    end else if (state == DONE) begin
      lock_act <= gnt_id ? m1_lock : m0_lock;
      lock_id  <= gnt_id;
    end else if (state == IDLE) begin
      lock_act <= 1'b0;
    end
  end
`else
  assign lock_mask = 2'b11;
`endif

  busarb_rr u_rr (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .mask     (lock_mask),
    .gnt_valid(rr_vld),
    .gnt_id   (rr_id)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      gnt_id    <= 1'b0;
      cnt       <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      bus_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_vld) begin
            gnt_id    <= rr_id;
            bus_we    <= rr_id ? m1_we    : m0_we;
            bus_addr  <= rr_id ? m1_addr  : m0_addr;
            bus_wdata <= rr_id ? m1_wdata : m0_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= BUSARB_CNT_W'(READ_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= 1) begin
            if (gnt_id) m1_rdata <= bus_rdata;
            else        m0_rdata <= bus_rdata;
            m0_ack <= ~gnt_id;
            m1_ack <= gnt_id;
            state  <= DONE;
          end
        end
        DONE: begin
          last_gnt <= gnt_id;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_busarb.sv
// Bench for busarb: directed cycle-exact scenarios plus a randomized run against a transaction-level model.
module tb_busarb;
  localparam int AW = 17;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata, rd_drv;
  logic          rmode;
`ifdef BUSARB_LOCK_EN
  logic          m0_lock, m1_lock;
`endif

  logic          r3_req, r3_ack, r3_m1_ack, r3_bus_we;
  logic [AW-1:0] r3_addr, r3_bus_addr;
  logic [DW-1:0] r3_rdata, r3_m1_rdata, r3_bus_wdata, r3_bus_rdata;

  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] hsh(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h3C;
  endfunction

  // Behaves like busctl: read data is a fixed function of the presented address.
  assign bus_rdata = rmode ? hsh(bus_addr) : rd_drv;

  busarb #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef BUSARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  busarb #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(r3_req), .m0_we(1'b0), .m0_addr(r3_addr), .m0_wdata('0),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr('0), .m1_wdata('0),
`ifdef BUSARB_LOCK_EN
    .m0_lock(1'b0), .m1_lock(1'b0),
`endif
    .m0_ack(r3_ack), .m1_ack(r3_m1_ack), .m0_rdata(r3_rdata), .m1_rdata(r3_m1_rdata),
    .bus_we(r3_bus_we), .bus_addr(r3_bus_addr), .bus_wdata(r3_bus_wdata), .bus_rdata(r3_bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({m0_ack, m1_ack, bus_we, bus_addr, bus_wdata, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b%b we=%b addr=%h wdata=%h rd0=%h rd1=%h, required all 0",
               m1_ack, m0_ack, bus_we, bus_addr, bus_wdata, m0_rdata, m1_rdata);
    end
    checks++;
    if ({r3_ack, r3_m1_ack, r3_bus_we, r3_bus_addr, r3_bus_wdata, r3_rdata, r3_m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_lat3: addr=%h rd0=%h, required all 0", r3_bus_addr, r3_rdata);
    end
  endtask

  task automatic test_single_read();
    m0_we = 1'b0; m0_addr = 17'h1ABCD; rd_drv = 8'hFF; m0_req = 1'b1;
    step();
    checks++;
    if (bus_addr !== 17'h1ABCD || bus_we !== 1'b0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: addr=%h we=%b ack=%b, required addr=1abcd we=0 ack=0", bus_addr, bus_we, m0_ack);
    end
    step();
    rd_drv = 8'h5A;
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_early_ack: ack=%b in cycle 2, required 0", m0_ack);
    end
    step();
    rd_drv = 8'hFF;
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_ack: ack0=%b ack1=%b rdata=%h, required 1 0 5a", m0_ack, m1_ack, m0_rdata);
    end
    m0_req = 1'b0;
    step();
    checks++;
    if (m0_ack !== 1'b0 || m0_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_hold: ack=%b rdata=%h, required 0 5a", m0_ack, m0_rdata);
    end
  endtask

  task automatic test_single_write();
    m1_we = 1'b1; m1_addr = 17'h00010; m1_wdata = 8'hC3; m1_req = 1'b1;
    step();
    checks++;
    if (bus_we !== 1'b1 || bus_addr !== 17'h00010 || bus_wdata !== 8'hC3) begin
      errors++;
      $display("FAIL write_issue: we=%b addr=%h wdata=%h, required 1 00010 c3", bus_we, bus_addr, bus_wdata);
    end
    step();
    checks++;
    if (bus_we !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_wait: we=%b ack=%b, required 0 0", bus_we, m1_ack);
    end
    step();
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 17'h00010) begin
      errors++;
      $display("FAIL write_ack: ack1=%b ack0=%b we=%b addr=%h, required 1 0 0 00010",
               m1_ack, m0_ack, bus_we, bus_addr);
    end
    m1_req = 1'b0; m1_we = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    int acks;
    m0_we = 1'b0; m0_addr = 17'h00777; m0_req = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({m0_ack, m1_ack, bus_we, bus_addr, bus_wdata, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: addr=%h wdata=%h rd0=%h rd1=%h ack=%b%b, required all 0",
               bus_addr, bus_wdata, m0_rdata, m1_rdata, m1_ack, m0_ack);
    end
    step();
    m0_req = 1'b0;
    reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m0_ack || m1_ack || bus_we || bus_addr != '0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL abort_idle: %0d busy cycles after release, required 0", acks);
    end
  endtask

  task automatic test_contention();
    logic exp_id[4];
    int   exp_cyc[4];
    int   n;
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_cyc = '{3, 7, 11, 15};
    n = 0;
    rd_drv = 8'h11;
    m0_we = 1'b0; m0_addr = 17'h00100;
    m1_we = 1'b1; m1_addr = 17'h00200; m1_wdata = 8'h22;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      step();
      if (m0_ack || m1_ack) begin
        checks++;
        if ((m0_ack && m1_ack) || m1_ack !== exp_id[n] || c != exp_cyc[n]) begin
          errors++;
          $display("FAIL contention_%0d: ack1=%b ack0=%b at cycle %0d, required master %0d at cycle %0d",
                   n, m1_ack, m0_ack, c, exp_id[n], exp_cyc[n]);
        end
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL contention_count: %0d acks, required 4", n);
    end
    step();
    step();
  endtask

  task automatic test_read_lat3();
    r3_bus_rdata = 8'hFF; r3_addr = 17'h0F0F0; r3_req = 1'b1;
    step();
    checks++;
    if (r3_bus_addr !== 17'h0F0F0 || r3_bus_we !== 1'b0) begin
      errors++;
      $display("FAIL lat3_issue: addr=%h we=%b, required 0f0f0 0", r3_bus_addr, r3_bus_we);
    end
    step();
    step();
    step();
    r3_bus_rdata = 8'h5A;
    checks++;
    if (r3_ack !== 1'b0) begin
      errors++;
      $display("FAIL lat3_early_ack: ack=%b in cycle 4, required 0", r3_ack);
    end
    step();
    r3_bus_rdata = 8'hFF;
    checks++;
    if (r3_ack !== 1'b1 || r3_m1_ack !== 1'b0 || r3_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL lat3_ack: ack0=%b ack1=%b rdata=%h in cycle 5, required 1 0 5a", r3_ack, r3_m1_ack, r3_rdata);
    end
    r3_req = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic          pend[2], just[2], t_we[2];
    logic [AW-1:0] t_addr[2];
    logic [DW-1:0] t_wd[2];
    logic          busy, last, exp_id, ok;
    int            idle_from, exp_cyc, we_seen, n_done;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_wd, got;
    pend = '{1'b0, 1'b0}; t_we = '{1'b0, 1'b0};
    t_addr = '{'0, '0}; t_wd = '{'0, '0};
    busy = 1'b0; last = 1'b1; exp_id = 1'b0;
    idle_from = 0; exp_cyc = 0; we_seen = 0; n_done = 0;
    we_addr = '0; we_wd = '0;
    rmode = 1'b1;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      step();
      just = '{1'b0, 1'b0};
      if (bus_we) begin
        we_seen++; we_addr = bus_addr; we_wd = bus_wdata;
      end
      if (busy && c == exp_cyc) begin
        checks++;
        if ({m1_ack, m0_ack} !== (exp_id ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rnd_ack: cycle %0d ack1=%b ack0=%b, required master %0d", c, m1_ack, m0_ack, exp_id);
        end
        got = exp_id ? m1_rdata : m0_rdata;
        if (t_we[exp_id]) ok = (we_seen == 1) && (we_addr == t_addr[exp_id]) && (we_wd == t_wd[exp_id]);
        else              ok = (we_seen == 0) && (got === hsh(t_addr[exp_id]));
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL rnd_data: m%0d we=%b addr=%h wd=%h; saw %0d pulses addr=%h wd=%h rdata=%h, required rdata=%h",
                   exp_id, t_we[exp_id], t_addr[exp_id], t_wd[exp_id], we_seen, we_addr, we_wd, got, hsh(t_addr[exp_id]));
        end
        busy = 1'b0; last = exp_id; idle_from = c + 1;
        pend[exp_id] = 1'b0; just[exp_id] = 1'b1; n_done++;
      end else if (m0_ack || m1_ack) begin
        checks++; errors++;
        $display("FAIL rnd_spurious: cycle %0d ack1=%b ack0=%b, required none", c, m1_ack, m0_ack);
      end
      for (int m = 0; m < 2; m++) begin
        if (c < 650 && !pend[m] && ((just[m] && $urandom_range(1, 0) == 1) ||
                                     (!just[m] && $urandom_range(2, 0) == 0))) begin
          pend[m] = 1'b1; t_we[m] = 1'($urandom_range(1, 0));
          t_addr[m] = AW'($urandom); t_wd[m] = DW'($urandom);
        end
      end
      m0_req = pend[0]; m0_we = t_we[0]; m0_addr = t_addr[0]; m0_wdata = t_wd[0];
      m1_req = pend[1]; m1_we = t_we[1]; m1_addr = t_addr[1]; m1_wdata = t_wd[1];
      // Arbiter is free from the cycle after an ack; the first request seen then is granted.
      if (!busy && c >= idle_from && (m0_req || m1_req)) begin
        exp_id  = (m0_req && m1_req) ? ~last : m1_req;
        busy    = 1'b1;
        exp_cyc = c + 3;
        we_seen = 0;
      end
    end
    checks++;
    if (busy || pend[0] || pend[1] || n_done < 50) begin
      errors++;
      $display("FAIL rnd_drain: busy=%b pend=%b%b done=%0d, required idle with >=50 transfers",
               busy, pend[1], pend[0], n_done);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    rmode = 1'b0;
  endtask

`ifdef BUSARB_LOCK_EN
  task automatic test_lock();
    logic exp_id[4];
    int   n, n1;
    exp_id = '{1'b1, 1'b1, 1'b1, 1'b0};
    n = 0; n1 = 0;
    do_reset();
    m1_we = 1'b0; m1_addr = 17'h00333; m1_lock = 1'b1; m1_req = 1'b1;
    m0_we = 1'b0; m0_addr = 17'h00444;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      if (m0_ack || m1_ack) begin
        checks++;
        if ((m0_ack && m1_ack) || m1_ack !== exp_id[n]) begin
          errors++;
          $display("FAIL lock_%0d: ack1=%b ack0=%b, required master %0d", n, m1_ack, m0_ack, exp_id[n]);
        end
        if (m1_ack) n1++;
        n++;
        m0_req = 1'b1;
        if (n1 == 3) m1_lock = 1'b0;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL lock_count: %0d acks, required 4", n);
    end
    step();
    step();
  endtask
`endif

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
`ifdef BUSARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    rd_drv = '0; rmode = 1'b0;
    r3_req = 1'b0; r3_addr = '0; r3_bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    step();
    step();
    test_single_read();
    test_single_write();
    test_reset_abort();
    test_contention();
    test_read_lat3();
    test_random();
`ifdef BUSARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/busarb.md
# busarb

Two-master bus arbiter that sits directly upstream of `busctl`. It accepts single-byte read/write transactions from the CPU `domain` (master 0) and the debug unit `dbgctl` (master 1), serialises them with round-robin priority, and drives `busctl`'s `write_en` / `addr_in` / `data_in`. It returns `data_out` to the granted master with a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 17: bus address width.
- `DATA_W`, 8: bus data width.
- `READ_LAT`, 1: cycles from the address being presented to `bus_rdata` being valid; legal range 1..7.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  transaction request; hold high until the matching ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `m0_addr`, `m1_addr`  in  ADDR_W  address; stable while req is high.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data; stable while req is high.
- `m0_lock`, `m1_lock`  in  1  request to keep the grant for the next transfer; present only with `BUSARB_LOCK_EN`.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data; valid in the ack cycle and held until that master's next ack.
- `bus_we`  out  1  to `busctl.write_en`.
- `bus_addr`  out  ADDR_W  to `busctl.addr_in`.
- `bus_wdata`  out  DATA_W  to `busctl.data_in`.
- `bus_rdata`  in  DATA_W  from `busctl.data_out`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Samples both req inputs.
  - If neither is high, stay in IDLE.
  - If only one is high, grant that master.
  - If both are high, grant the master that was not granted last (`last_gnt`, reset value 1, so m0 wins the first contention).
  - On a grant: latch the winner's `we`/`addr`/`wdata` into `bus_we_q`/`bus_addr`/`bus_wdata`, set `gnt_id`, go to ISSUE.
- **ISSUE** (1 cycle)
  - `bus_we` = latched `we`; `bus_addr`/`bus_wdata` driven from the latch.
  - Load the latency counter with `READ_LAT`, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle; `bus_we` = 0.
  - When the counter reaches 1, capture `bus_rdata` into the granted master's rdata register (writes capture as well; the value is don't-care to the master) and go to DONE.
- **DONE** (1 cycle)
  - Pulse `mN_ack` for `gnt_id`.
  - Update `last_gnt` = `gnt_id`, then go to IDLE.
  - Requests are ignored in DONE.
- `bus_addr` and `bus_wdata` hold their last latched values outside ISSUE. `bus_we` is high only in ISSUE.
- Both acks are never asserted in the same cycle.
- A master that drops req before its ack is a protocol violation. The transaction still completes and the ack is still issued.

## Timing
- Reset (async assert, sync deassert by the system): state = IDLE, `last_gnt` = 1, all acks 0, `bus_we` 0, `bus_addr` 0, `bus_wdata` 0, both rdata registers 0, counter 0.
- Reset asserted mid-transaction aborts it; no ack is issued.
- Latency: with req sampled high in IDLE at cycle 0, ack is high in cycle 2 + `READ_LAT` (3 for the default).
- Throughput: one transfer per 3 + `READ_LAT` cycles.
- A master holding req high through its ack cycle starts a new transfer in the following IDLE cycle. Masters with registered req logic therefore drop req in the cycle after ack when they have no further work.

## Configuration
- `BUSARB_LOCK_EN` defined:
  - `mN_lock` ports exist.
  - If the granted master's lock is high in its DONE cycle, the next IDLE considers only that master.
  - If that master's req is low in that IDLE cycle, the lock is released and normal arbitration applies on the next cycle.
  - `last_gnt` still updates on each DONE.
- `BUSARB_LOCK_EN` undefined: lock ports and lock logic are absent; pure round-robin.

## Structure
- `busarb_pkg`: state enum `busarb_state_t` (IDLE, ISSUE, WAIT, DONE), default `ADDR_W`/`DATA_W`/`READ_LAT` localparams, master id type.
- Sub-module `busarb_rr`: combinational two-input round-robin picker taking req vector, `last_gnt` and lock mask, producing `gnt_valid`/`gnt_id`.
- The FSM, latches and counter live in `busarb`.

## Test plan
- Reset values: assert `reset`=0 mid-WAIT -> all outputs 0, no ack, FSM back in IDLE; release -> idle bus.
- Single read: m0 read addr 0x1ABCD, `bus_rdata`=0x5A -> `bus_addr`=0x1ABCD in cycle 1, `bus_we`=0, `m0_ack` in cycle 3, `m0_rdata`=0x5A.
- Single write: m1 write addr 0x00010, data 0xC3 -> `bus_we`=1 for exactly cycle 1, `bus_wdata`=0xC3, `m1_ack` in cycle 3.
- Contention: both req high continuously, 4 transfers -> grant order m0, m1, m0, m1; each ack 4 cycles apart.
- `READ_LAT`=3: m0 read -> ack in cycle 5, data captured from `bus_rdata` in cycle 4.
- `BUSARB_LOCK_EN`: m1 lock=1 and both req high -> m1 gets 3 consecutive transfers. m1 drops lock -> next grant m0.
